// File: rtl/retry_buffer_tracker_pkg.sv
// Shared types and helpers for the data-link retry tracker.
package pcie_datalink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TIMING,
    ST_REPLAY
  } retry_tracker_st_e;

  // Modular distance (a - b) mod 2^width, computed on a 32-bit carrier.
  function automatic logic [31:0] seq_distance(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/retry_buffer_tracker_timer.sv
// Shared replay timer plus REPLAY_NUM counter with a registered rollover pulse.
module retry_replay_timer #(
  parameter int REPLAY_TIMEOUT   = 160,
  parameter int REPLAY_NUM_WIDTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_progress,
  input  logic i_hold,
  input  logic i_start_replay,
  output logic o_timeout,
  output logic o_wrap,
  output logic o_rollover
);

  localparam int TW = (REPLAY_TIMEOUT > 2) ? $clog2(REPLAY_TIMEOUT) : 1;

  logic [TW-1:0]               r_timer;
  logic [REPLAY_NUM_WIDTH-1:0] r_num;
  logic                        r_rollover;
  logic [REPLAY_NUM_WIDTH-1:0] w_base;

  // Forward progress in the same cycle as a replay start restarts the count first.
  assign w_base     = i_progress ? '0 : r_num;
  assign o_timeout  = !i_hold && !i_progress && (r_timer == TW'(REPLAY_TIMEOUT - 1));
  assign o_wrap     = i_start_replay && (w_base == '1);
  assign o_rollover = r_rollover;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timer    <= '0;
      r_num      <= '0;
      r_rollover <= 1'b0;
    end else begin
      if (i_hold || i_progress || o_timeout) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end
      r_rollover <= o_wrap;
      r_num      <= i_start_replay ? w_base + REPLAY_NUM_WIDTH'(1) : w_base;
    end
  end

endmodule

// File: rtl/retry_buffer_tracker.sv
// Retry slot tracker: circular queue of unacked TLPs, cumulative ACK/NAK release, ordered replay.
module retry_buffer_tracker
  import pcie_datalink_pkg::*;
#(
  parameter int RETRY_SLOTS      = 8,
  parameter int SEQ_WIDTH        = 12,
  parameter int REPLAY_TIMEOUT   = 160,
  parameter int REPLAY_NUM_WIDTH = 2,
  parameter int SLOT_W           = $clog2(RETRY_SLOTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tx_valid_i,
  input  logic [SEQ_WIDTH-1:0] tx_seq_num_i,
  output logic                 tx_ready_o,
  output logic [SLOT_W-1:0]    tx_slot_o,
  input  logic                 ack_nack_vld_i,
  input  logic                 ack_nack_i,
  input  logic [SEQ_WIDTH-1:0] ack_seq_num_i,
  output logic                 replay_valid_o,
  output logic [SLOT_W-1:0]    replay_slot_o,
  output logic [SEQ_WIDTH-1:0] replay_seq_o,
  input  logic                 replay_ready_i,
  output logic [SLOT_W:0]      outstanding_o,
  output logic                 retrain_req_o,
  output logic                 retry_err_o
);

  localparam logic [SLOT_W:0] FULL_C = (SLOT_W + 1)'(RETRY_SLOTS);

  retry_tracker_st_e    r_state;
  logic [SLOT_W-1:0]    r_head, r_tail, r_rp_slot;
  logic [SLOT_W:0]      r_count, r_rp_off;
  logic [SEQ_WIDTH-1:0] r_mem [RETRY_SLOTS];
  logic [SEQ_WIDTH-1:0] r_last_seq, r_rp_seq;
  logic                 r_rp_valid, r_err;

  logic                 w_tx_ready, w_accept, w_in_win, w_dup, w_bad_ack, w_nak;
  logic                 w_hs, w_lost, w_timeout, w_wrap, w_start, w_hold, w_retrain;
  logic [SEQ_WIDTH-1:0] w_head_seq, w_dist;
  logic [SLOT_W:0]      w_freed, w_count_next, w_off_adv, w_off_new;
  logic [SLOT_W-1:0]    w_head_next, w_rp_slot_next;

  assign w_tx_ready = (r_count != FULL_C) && (r_state != ST_REPLAY);
  assign w_accept   = tx_valid_i && w_tx_ready;

  // When empty, the virtual head is one past the last freed seq so only a duplicate is legal.
  assign w_head_seq = (r_count == '0) ? r_last_seq + SEQ_WIDTH'(1) : r_mem[r_head];
  assign w_dist     = SEQ_WIDTH'(seq_distance(32'(ack_seq_num_i), 32'(w_head_seq), SEQ_WIDTH));
  assign w_in_win   = ack_nack_vld_i && (w_dist < SEQ_WIDTH'(r_count));
  assign w_dup      = ack_nack_vld_i && (w_dist == '1);
  assign w_bad_ack  = ack_nack_vld_i && !w_in_win && !w_dup;
  assign w_nak      = ack_nack_vld_i && !ack_nack_i && (w_in_win || w_dup);

  assign w_freed      = w_in_win ? w_dist[SLOT_W:0] + (SLOT_W + 1)'(1) : '0;
  assign w_head_next  = r_head + w_freed[SLOT_W-1:0];
  assign w_count_next = r_count + (SLOT_W + 1)'(w_accept) - w_freed;

  // Replay position is kept as an offset from head so ACKs simply slide it down.
  assign w_hs           = r_rp_valid && replay_ready_i;
  assign w_off_adv      = r_rp_off + (SLOT_W + 1)'(w_hs);
  assign w_off_new      = w_nak ? '0 : ((w_off_adv > w_freed) ? w_off_adv - w_freed : '0);
  assign w_lost         = r_rp_valid && !replay_ready_i && (w_nak || (r_rp_off < w_freed));
  assign w_rp_slot_next = w_head_next + w_off_new[SLOT_W-1:0];

  assign w_hold  = (r_state != ST_TIMING);
  assign w_start = (r_state == ST_TIMING) && (w_count_next != '0) && (w_nak || w_timeout);

  retry_replay_timer #(
    .REPLAY_TIMEOUT  (REPLAY_TIMEOUT),
    .REPLAY_NUM_WIDTH(REPLAY_NUM_WIDTH)
  ) u_timer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .i_progress    (w_in_win),
    .i_hold        (w_hold),
    .i_start_replay(w_start),
    .o_timeout     (w_timeout),
    .o_wrap        (w_wrap),
    .o_rollover    (w_retrain)
  );

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_mem[r_tail] <= tx_seq_num_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_last_seq <= '1;
      r_rp_off   <= '0;
      r_rp_valid <= 1'b0;
      r_rp_slot  <= '0;
      r_rp_seq   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_head  <= w_head_next;
      r_count <= w_count_next;
      if (w_accept) begin
        r_tail <= r_tail + SLOT_W'(1);
      end
      if (w_in_win) begin
        r_last_seq <= ack_seq_num_i;
      end
      if (w_bad_ack || (tx_valid_i && !w_tx_ready) || w_wrap) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_TIMING;
          end
        end
        ST_TIMING: begin
          if (w_count_next == '0) begin
            r_state <= ST_IDLE;
          end else if (w_start) begin
            r_state    <= ST_REPLAY;
            r_rp_off   <= '0;
            r_rp_valid <= 1'b0;
          end
        end
        ST_REPLAY: begin
          r_rp_off <= w_off_new;
          if (w_count_next == '0) begin
            r_state    <= ST_IDLE;
            r_rp_valid <= 1'b0;
          end else if (w_off_new == w_count_next) begin
            r_state    <= ST_TIMING;
            r_rp_valid <= 1'b0;
          end else if (w_lost) begin
            r_rp_valid <= 1'b0;
          end else begin
            r_rp_valid <= 1'b1;
            r_rp_slot  <= w_rp_slot_next;
            r_rp_seq   <= r_mem[w_rp_slot_next];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready_o     = w_tx_ready;
  assign tx_slot_o      = r_tail;
  assign outstanding_o  = r_count;
  assign replay_valid_o = r_rp_valid;
  assign replay_slot_o  = r_rp_slot;
  assign replay_seq_o   = r_rp_seq;
  assign retrain_req_o  = w_retrain;
  assign retry_err_o    = r_err;

endmodule

// File: tb/tb_retry_buffer_tracker.sv
// Bench for retry_buffer_tracker: queue-based reference model checked every cycle, plus directed pins.
module tb_retry_buffer_tracker;

  localparam int S    = 8;
  localparam int T    = 160;
  localparam int M    = 4095;
  localparam int NMAX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_valid = 1'b0;
  logic [11:0] tx_seq = '0;
  logic        av = 1'b0;
  logic        an = 1'b0;
  logic [11:0] aseq = '0;
  logic        rr = 1'b0;

  logic        tx_ready_o, replay_valid_o, retrain_req_o, retry_err_o;
  logic [2:0]  tx_slot_o, replay_slot_o;
  logic [11:0] replay_seq_o;
  logic [3:0]  outstanding_o;

  always #5 clk = ~clk;

  retry_buffer_tracker dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tx_valid_i    (tx_valid),
    .tx_seq_num_i  (tx_seq),
    .tx_ready_o    (tx_ready_o),
    .tx_slot_o     (tx_slot_o),
    .ack_nack_vld_i(av),
    .ack_nack_i    (an),
    .ack_seq_num_i (aseq),
    .replay_valid_o(replay_valid_o),
    .replay_slot_o (replay_slot_o),
    .replay_seq_o  (replay_seq_o),
    .replay_ready_i(rr),
    .outstanding_o (outstanding_o),
    .retrain_req_o (retrain_req_o),
    .retry_err_o   (retry_err_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of outstanding seqs, absolute head index, replay cursor in absolute TLP numbers.
  int m_q[$];
  int m_base = 0, m_last = M, m_mode = 0, m_timer = 0, m_rnum = 0;
  int m_cur = 0, m_rslot = 0, m_rseq = 0;
  bit m_rv = 0, m_retrain = 0, m_err = 0;
  bit chk_en = 0;

  always @(posedge clk) begin : model
    int  d, hseq, freed, offd;
    bit  rdy, acc, legal, nak, hsk, tmo, strt, prog, lost;
    if (rst) begin
      m_q.delete();
      m_base = 0; m_last = M; m_mode = 0; m_timer = 0; m_rnum = 0;
      m_cur = 0; m_rslot = 0; m_rseq = 0; m_rv = 0; m_retrain = 0; m_err = 0;
    end else begin
      rdy = (m_q.size() < S) && (m_mode != 2);
      acc = tx_valid && rdy;
      if (tx_valid && !rdy) m_err = 1;
      freed = 0;
      legal = 0;
      if (av) begin
        hseq = (m_q.size() > 0) ? m_q[0] : ((m_last + 1) & M);
        d = (int'(aseq) - hseq) & M;
        if (d < m_q.size()) begin
          freed = d + 1;
          legal = 1;
        end else if (d == M) begin
          legal = 1;
        end else begin
          m_err = 1;
        end
      end
      nak = av && !an && legal;
      hsk = m_rv && rr;
      for (int i = 0; i < freed; i++) void'(m_q.pop_front());
      m_base += freed;
      if (freed > 0) m_last = int'(aseq);
      if (acc) m_q.push_back(int'(tx_seq));
      prog = (freed > 0);
      tmo  = (m_mode == 1) && !prog && (m_timer == T - 1);
      strt = (m_mode == 1) && (m_q.size() > 0) && (nak || tmo);
      m_retrain = 0;
      if (prog) m_rnum = 0;
      if (strt) begin
        if (m_rnum == NMAX) begin
          m_rnum = 0; m_retrain = 1; m_err = 1;
        end else begin
          m_rnum++;
        end
      end
      if (m_mode != 1 || prog || tmo) m_timer = 0;
      else m_timer++;
      case (m_mode)
        0: if (acc) m_mode = 1;
        1: begin
          if (m_q.size() == 0) m_mode = 0;
          else if (strt) begin
            m_mode = 2; m_cur = m_base; m_rv = 0;
          end
        end
        default: begin
          offd = m_cur;
          if (hsk) m_cur++;
          if (nak) m_cur = m_base;
          lost = m_rv && !rr && (nak || offd < m_base);
          if (m_cur < m_base) m_cur = m_base;
          if (m_q.size() == 0) begin
            m_mode = 0; m_rv = 0;
          end else if (m_cur == m_base + m_q.size()) begin
            m_mode = 1; m_rv = 0;
          end else if (lost) begin
            m_rv = 0;
          end else begin
            m_rv = 1; m_rslot = m_cur % S; m_rseq = m_q[m_cur - m_base];
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_ready", int'(tx_ready_o), int'((m_q.size() < S) && (m_mode != 2)));
      chk("tx_slot", int'(tx_slot_o), (m_base + m_q.size()) % S);
      chk("outstanding", int'(outstanding_o), m_q.size());
      chk("replay_valid", int'(replay_valid_o), int'(m_rv));
      chk("replay_slot", int'(replay_slot_o), m_rslot);
      chk("replay_seq", int'(replay_seq_o), m_rseq);
      chk("retrain_req", int'(retrain_req_o), int'(m_retrain));
      chk("retry_err", int'(retry_err_o), int'(m_err));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_tx(input int s);
    tx_valid = 1'b1;
    tx_seq   = 12'(s);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic send_ack(input bit is_ack, input int s);
    av   = 1'b1;
    an   = is_ack;
    aseq = 12'(s);
    @(negedge clk);
    av = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int k, rises, pulses, rises_at, next_seq, r, kind;
    bit prev;
    int tp[4] = '{50, 30, 60, 10};
    int ap[4] = '{30, 3, 10, 1};
    int rp[4] = '{70, 50, 20, 90};

    @(negedge clk);
    do_reset();
    chk_en = 1;
    chk("rst_outstanding", int'(outstanding_o), 0);
    chk("rst_tx_ready", int'(tx_ready_o), 1);
    chk("rst_replay_valid", int'(replay_valid_o), 0);
    chk("rst_err", int'(retry_err_o), 0);

    // Fill to capacity, then cumulative ACK of seq 3.
    for (int i = 0; i < 8; i++) send_tx(i);
    chk("full_outstanding", int'(outstanding_o), 8);
    chk("full_tx_ready", int'(tx_ready_o), 0);
    send_ack(1'b1, 3);
    chk("ack3_outstanding", int'(outstanding_o), 4);
    chk("ack3_tx_ready", int'(tx_ready_o), 1);
    send_ack(1'b1, 7);
    chk("ack7_outstanding", int'(outstanding_o), 0);

    // Sequence wrap around 4095.
    send_tx(4094); send_tx(4095); send_tx(0); send_tx(1);
    send_ack(1'b1, 0);
    chk("wrap_outstanding", int'(outstanding_o), 1);
    chk("wrap_err_clear", int'(retry_err_o), 0);
    send_ack(1'b1, 2000);
    chk("oow_err", int'(retry_err_o), 1);
    chk("oow_outstanding", int'(outstanding_o), 1);
    send_ack(1'b1, 1);
    chk("head1_outstanding", int'(outstanding_o), 0);

    // Timeout latency.
    do_reset();
    rr = 1'b1;
    send_tx(10);
    k = 0;
    while (!replay_valid_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_cycle", k, 161);
    chk("timeout_seq", int'(replay_seq_o), 10);
    @(negedge clk);
    send_ack(1'b1, 10);

    // NAK replay with ready held high.
    do_reset();
    for (int i = 20; i < 24; i++) send_tx(i);
    send_ack(1'b0, 21);
    @(negedge clk);
    chk("nak_first_valid", int'(replay_valid_o), 1);
    chk("nak_first_seq", int'(replay_seq_o), 22);
    chk("nak_first_slot", int'(replay_slot_o), 2);
    @(negedge clk);
    chk("nak_second_seq", int'(replay_seq_o), 23);
    chk("nak_second_slot", int'(replay_slot_o), 3);
    @(negedge clk);
    chk("nak_done_valid", int'(replay_valid_o), 0);
    chk("nak_done_ready", int'(tx_ready_o), 1);
    chk("nak_done_outstanding", int'(outstanding_o), 2);
    send_ack(1'b1, 23);

    // Four timeouts: rollover on the fourth.
    do_reset();
    send_tx(50);
    rises = 0; pulses = 0; rises_at = -1; prev = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (replay_valid_o && !prev) rises++;
      if (retrain_req_o) begin
        pulses++;
        rises_at = rises;
      end
      prev = replay_valid_o;
    end
    chk("rollover_replays", rises, 4);
    chk("rollover_pulses", pulses, 1);
    chk("rollover_at_entry4", rises_at, 3);
    chk("rollover_err", int'(retry_err_o), 1);
    send_ack(1'b1, 50);

    // Stalled replay, ACK frees the requested slot, then reset mid-replay.
    do_reset();
    rr = 1'b0;
    for (int i = 30; i < 34; i++) send_tx(i);
    send_ack(1'b0, 29);
    k = 0;
    while (!replay_valid_o && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("stall_seq0", int'(replay_seq_o), 30);
    @(negedge clk);
    @(negedge clk);
    chk("stall_hold_valid", int'(replay_valid_o), 1);
    chk("stall_hold_seq", int'(replay_seq_o), 30);
    send_ack(1'b1, 31);
    chk("freed_drop_valid", int'(replay_valid_o), 0);
    k = 0;
    while (!replay_valid_o && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("freed_next_seq", int'(replay_seq_o), 32);
    chk("freed_next_slot", int'(replay_slot_o), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", int'(replay_valid_o), 0);
    chk("midrst_outstanding", int'(outstanding_o), 0);
    chk("midrst_ready", int'(tx_ready_o), 1);
    chk("midrst_slot", int'(replay_slot_o), 0);
    chk("midrst_seq", int'(replay_seq_o), 0);
    chk("midrst_tx_slot", int'(tx_slot_o), 0);
    chk("midrst_err", int'(retry_err_o), 0);

    // Randomised traffic in phases of differing ACK pressure.
    next_seq = 0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 1500; c++) begin
        rst = ($urandom_range(0, 499) == 0);
        tx_valid = ($urandom_range(0, 99) < tp[ph]);
        tx_seq   = 12'(next_seq);
        if (tx_valid && (m_q.size() < S) && (m_mode != 2) && !rst) next_seq = (next_seq + 1) & M;
        r = $urandom_range(0, 99);
        av = (r < ap[ph]);
        an = ($urandom_range(0, 3) != 0);
        kind = $urandom_range(0, 9);
        if (m_q.size() > 0 && kind < 7) aseq = 12'(m_q[$urandom_range(0, m_q.size() - 1)]);
        else if (kind < 9) aseq = 12'((m_q.size() > 0) ? ((m_q[0] - 1) & M) : m_last);
        else aseq = 12'($urandom_range(0, M));
        rr = ($urandom_range(0, 99) < rp[ph]);
        @(negedge clk);
      end
    end
    rst = 1'b0; tx_valid = 1'b0; av = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
